id_ex_stage: RTL and testbench

- Parametrised decode stage with an ID/EX pipeline register. It holds the architectural register file, reads rs1/rs2, generates the sign-extended immediate per RISC-V format, and registers the control bundle.
- Adds what the previous stage lacked: a valid/ready handshake, flush, load-use bubble insertion and write-back bypass.
- Sits between the fetch stage (in_*) and the execute stage (out_*). The write-back stage drives wb_*.

---
 rtl/id_ex_pkg.sv | 39 +++
 rtl/id_ex_stage_imm_gen.sv | 38 +++
 rtl/id_ex_stage_reg_file.sv | 69 ++++++
 rtl/id_ex_stage.sv | 129 ++++++++++++
 tb/tb_id_ex_stage.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/id_ex_pkg.sv
// id_ex_pkg: shared constants and types for the decode / ID-EX stage.
//   - RISC-V base opcodes that carry an immediate
//   - imm_fmt_t: immediate format selector
//   - imm_fmt_of(): maps an opcode onto its immediate format
package id_ex_pkg;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        FMT_I    = 3'd0,
        FMT_S    = 3'd1,
        FMT_B    = 3'd2,
        FMT_U    = 3'd3,
        FMT_J    = 3'd4,
        FMT_NONE = 3'd5
    } imm_fmt_t;

    // Opcode to immediate-format lookup; unknown opcodes carry no immediate.
    function automatic imm_fmt_t imm_fmt_of(input logic [6:0] opcode);
        imm_fmt_t fmt;
        case (opcode)
            OP_IMM, OP_LOAD, OP_JALR: fmt = FMT_I;
            OP_STORE:                 fmt = FMT_S;
            OP_BRANCH:                fmt = FMT_B;
            OP_LUI, OP_AUIPC:         fmt = FMT_U;
            OP_JAL:                   fmt = FMT_J;
            default:                  fmt = FMT_NONE;
        endcase
        return fmt;
    endfunction

endpackage

// File: rtl/id_ex_stage_imm_gen.sv
// imm_gen: combinational RISC-V immediate generator.
//   instr : 32-bit instruction word
//   imm   : immediate, sign-extended to XLEN (0 for opcodes without one)
// The 32-bit immediate is assembled first and then sign-extended to XLEN,
// so XLEN == 32 needs no zero-width replication.
module imm_gen
    import id_ex_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm
);

    imm_fmt_t    fmt_s;
    logic [31:0] imm32_s;

    assign fmt_s = imm_fmt_of(instr[6:0]);

    // Assemble the 32-bit immediate for the decoded format.
    always_comb begin
        imm32_s = 32'd0;
        case (fmt_s)
            FMT_I:   imm32_s = {{20{instr[31]}}, instr[31:20]};
            FMT_S:   imm32_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   imm32_s = {{19{instr[31]}}, instr[31], instr[7],
                                instr[30:25], instr[11:8], 1'b0};
            FMT_U:   imm32_s = {instr[31:12], 12'd0};
            FMT_J:   imm32_s = {{11{instr[31]}}, instr[31], instr[19:12],
                                instr[20], instr[30:21], 1'b0};
            FMT_NONE: imm32_s = 32'd0;
            default: imm32_s = 32'd0;
        endcase
    end

    assign imm = XLEN'($signed(imm32_s));

endmodule

// File: rtl/id_ex_stage_reg_file.sv
// reg_file: architectural register file, two combinational read ports,
// one synchronous write port. x0 always reads zero and ignores writes.
//   clk, rst            : clock, asynchronous active-low reset (clears all)
//   rd_addr1/2, rd_data1/2 : read ports
//   wb_we, wb_addr, wb_data : write port
// Optional macro ID_EX_WB_BYPASS_EN: a same-cycle write to the address being
// read is forwarded to the read port (write-first). Without it the read
// returns the stored value (read-before-write).
module reg_file #(
    parameter int XLEN    = 32,
    parameter int REG_CNT = 32,
    parameter int REG_AW  = $clog2(REG_CNT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rd_addr1,
    input  logic [REG_AW-1:0] rd_addr2,
    output logic [XLEN-1:0]   rd_data1,
    output logic [XLEN-1:0]   rd_data2,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [XLEN-1:0]   wb_data
);

    logic [XLEN-1:0] regs_r [REG_CNT];
    logic            wr_en_s;

    assign wr_en_s = wb_we && (wb_addr != {REG_AW{1'b0}});

    // Storage: asynchronous clear, write on clock when the target is not x0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < REG_CNT; i++) begin
                regs_r[i] <= {XLEN{1'b0}};
            end
        end else if (wr_en_s) begin
            regs_r[wb_addr] <= wb_data;
        end
    end

    // Read port 1: x0 is hard-wired to zero.
    always_comb begin
        rd_data1 = {XLEN{1'b0}};
        if (rd_addr1 == {REG_AW{1'b0}}) begin
            rd_data1 = {XLEN{1'b0}};
`ifdef ID_EX_WB_BYPASS_EN
        end else if (wr_en_s && (wb_addr == rd_addr1)) begin
            rd_data1 = wb_data;
`endif
        end else begin
            rd_data1 = regs_r[rd_addr1];
        end
    end

    // Read port 2: x0 is hard-wired to zero.
    always_comb begin
        rd_data2 = {XLEN{1'b0}};
        if (rd_addr2 == {REG_AW{1'b0}}) begin
            rd_data2 = {XLEN{1'b0}};
`ifdef ID_EX_WB_BYPASS_EN
        end else if (wr_en_s && (wb_addr == rd_addr2)) begin
            rd_data2 = wb_data;
`endif
        end else begin
            rd_data2 = regs_r[rd_addr2];
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: decode stage with ID/EX pipeline register.
// Reads rs1/rs2 from the register file, generates the immediate and
// registers operands, indices, PC and control towards execute, using a
// valid/ready handshake on both sides.
//   clk, rst (async, active-low)
//   in_valid/in_ready, instr_in, pc_in, ctrl_in : from fetch / control decoder
//   flush                                        : kill instruction entering ID/EX
//   wb_we, wb_addr, wb_data                      : write-back port
//   out_valid/out_ready, out_*                   : to execute
// A load in ID/EX whose rd matches rs1/rs2 of the incoming instruction
// inserts exactly one bubble. Macro ID_EX_WB_BYPASS_EN enables write-first
// forwarding inside the register file.
module id_ex_stage
    import id_ex_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int REG_CNT  = 32,
    parameter int REG_AW   = $clog2(REG_CNT),
    parameter int CTRL_W   = 8,
    parameter int LOAD_BIT = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr_in,
    input  logic [XLEN-1:0]   pc_in,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic              flush,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [XLEN-1:0]   wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_rs1_data,
    output logic [XLEN-1:0]   out_rs2_data,
    output logic [XLEN-1:0]   out_imm,
    output logic [XLEN-1:0]   out_pc,
    output logic [REG_AW-1:0] out_rs1,
    output logic [REG_AW-1:0] out_rs2,
    output logic [REG_AW-1:0] out_rd,
    output logic [CTRL_W-1:0] out_ctrl
);

    logic [REG_AW-1:0] rs1_s;
    logic [REG_AW-1:0] rs2_s;
    logic [REG_AW-1:0] rd_s;
    logic [XLEN-1:0]   rs1_data_s;
    logic [XLEN-1:0]   rs2_data_s;
    logic [XLEN-1:0]   imm_s;
    logic              le_s;
    logic              hz_s;

    assign rs1_s = instr_in[15 +: REG_AW];
    assign rs2_s = instr_in[20 +: REG_AW];
    assign rd_s  = instr_in[7  +: REG_AW];

    reg_file #(
        .XLEN    (XLEN),
        .REG_CNT (REG_CNT),
        .REG_AW  (REG_AW)
    ) u_reg_file (
        .clk      (clk),
        .rst      (rst),
        .rd_addr1 (rs1_s),
        .rd_addr2 (rs2_s),
        .rd_data1 (rs1_data_s),
        .rd_data2 (rs2_data_s),
        .wb_we    (wb_we),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data)
    );

    imm_gen #(
        .XLEN (XLEN)
    ) u_imm_gen (
        .instr (instr_in),
        .imm   (imm_s)
    );

    // The stage can take a new instruction when empty or when execute drains it.
    assign le_s = !out_valid || out_ready;

    // Load-use: the value of a load still in ID/EX is not yet in the register file.
    assign hz_s = in_valid && out_valid && out_ctrl[LOAD_BIT]
                  && (out_rd != {REG_AW{1'b0}})
                  && ((out_rd == rs1_s) || (out_rd == rs2_s));

    // A flush discards the incoming instruction, so it is consumed even on a hazard.
    assign in_ready = le_s && (!hz_s || flush);

    // ID/EX register: flush > load-use bubble > load > stall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid    <= 1'b0;
            out_ctrl     <= {CTRL_W{1'b0}};
            out_rs1_data <= {XLEN{1'b0}};
            out_rs2_data <= {XLEN{1'b0}};
            out_imm      <= {XLEN{1'b0}};
            out_pc       <= {XLEN{1'b0}};
            out_rs1      <= {REG_AW{1'b0}};
            out_rs2      <= {REG_AW{1'b0}};
            out_rd       <= {REG_AW{1'b0}};
        end else if (flush) begin
            out_valid <= 1'b0;
            out_ctrl  <= {CTRL_W{1'b0}};
        end else if (le_s && hz_s) begin
            out_valid <= 1'b0;
            out_ctrl  <= {CTRL_W{1'b0}};
        end else if (le_s) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_ctrl     <= ctrl_in;
                out_rs1_data <= rs1_data_s;
                out_rs2_data <= rs2_data_s;
                out_imm      <= imm_s;
                out_pc       <= pc_in;
                out_rs1      <= rs1_s;
                out_rs2      <= rs2_s;
                out_rd       <= rd_s;
            end else begin
                out_ctrl <= out_ctrl;
            end
        end else begin
            out_valid <= out_valid;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: self-checking bench for id_ex_stage (default parameters).
// Directed steps from the test plan followed by randomized traffic, all
// compared against a behavioural model kept in this file.
module tb_id_ex_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr_in;
    logic [31:0] pc_in;
    logic [7:0]  ctrl_in;
    logic        flush;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rs1_data;
    logic [31:0] out_rs2_data;
    logic [31:0] out_imm;
    logic [31:0] out_pc;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [4:0]  out_rd;
    logic [7:0]  out_ctrl;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_rf [32];
    logic        m_valid;
    logic [7:0]  m_ctrl;
    logic [31:0] m_d1, m_d2, m_imm, m_pc;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic        last_rdy;

    id_ex_stage dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .instr_in     (instr_in),
        .pc_in        (pc_in),
        .ctrl_in      (ctrl_in),
        .flush        (flush),
        .wb_we        (wb_we),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_rs1_data (out_rs1_data),
        .out_rs2_data (out_rs2_data),
        .out_imm      (out_imm),
        .out_pc       (out_pc),
        .out_rs1      (out_rs1),
        .out_rs2      (out_rs2),
        .out_rd       (out_rd),
        .out_ctrl     (out_ctrl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Immediate computed arithmetically from the RISC-V format definitions.
    function automatic logic [31:0] ref_imm(input logic [31:0] i);
        int t;
        case (i[6:0])
            7'h13, 7'h03, 7'h67: begin t = int'(i); t = t >>> 20; end
            7'h23: begin t = int'(i); t = ((t >>> 25) <<< 5) | int'({27'd0, i[11:7]}); end
            7'h63: begin
                t = int'({19'd0, i[31], i[7], i[30:25], i[11:8], 1'b0});
                t = t <<< 19; t = t >>> 19;
            end
            7'h37, 7'h17: t = int'(i & 32'hFFFFF000);
            7'h6F: begin
                t = int'({11'd0, i[31], i[19:12], i[20], i[30:21], 1'b0});
                t = t <<< 11; t = t >>> 11;
            end
            default: t = 0;
        endcase
        return 32'(t);
    endfunction

    function automatic logic [31:0] ref_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
`ifdef ID_EX_WB_BYPASS_EN
        if (wb_we && wb_addr == a) return wb_data;
`endif
        return m_rf[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
        m_valid = 1'b0; m_ctrl = 8'd0; m_d1 = 32'd0; m_d2 = 32'd0;
        m_imm = 32'd0; m_pc = 32'd0; m_rs1 = 5'd0; m_rs2 = 5'd0; m_rd = 5'd0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".out_valid"}, 64'(out_valid), 64'(m_valid));
        check({tag, ".out_ctrl"},  64'(out_ctrl),  64'(m_ctrl));
        check({tag, ".out_pc"},    64'(out_pc),    64'(m_pc));
        check({tag, ".out_imm"},   64'(out_imm),   64'(m_imm));
        check({tag, ".out_rs1"},   64'(out_rs1),   64'(m_rs1));
        check({tag, ".out_rs2"},   64'(out_rs2),   64'(m_rs2));
        check({tag, ".out_rd"},    64'(out_rd),    64'(m_rd));
        check({tag, ".rs1_data"},  64'(out_rs1_data), 64'(m_d1));
        check({tag, ".rs2_data"},  64'(out_rs2_data), 64'(m_d2));
    endtask

    task automatic drive(input logic iv, input logic [31:0] ins, input logic [31:0] p,
                         input logic [7:0] c, input logic fl, input logic ordy,
                         input logic we, input logic [4:0] wa, input logic [31:0] wd);
        in_valid = iv; instr_in = ins; pc_in = p; ctrl_in = c; flush = fl;
        out_ready = ordy; wb_we = we; wb_addr = wa; wb_data = wd;
    endtask

    // One clock: check in_ready, advance the model across the edge, check outputs.
    task automatic cycle(input string tag);
        logic [4:0]  r1, r2;
        logic [31:0] d1, d2;
        logic        le, hz;
        #1;
        r1 = instr_in[19:15];
        r2 = instr_in[24:20];
        le = !m_valid || out_ready;
        hz = in_valid && m_valid && m_ctrl[7] && (m_rd != 5'd0) && (m_rd == r1 || m_rd == r2);
        last_rdy = le && (!hz || flush);
        check({tag, ".in_ready"}, 64'(in_ready), 64'(last_rdy));
        d1 = ref_read(r1);
        d2 = ref_read(r2);
        @(posedge clk);
        if (flush || (le && hz)) begin
            m_valid = 1'b0; m_ctrl = 8'd0;
        end else if (le) begin
            m_valid = in_valid;
            if (in_valid) begin
                m_ctrl = ctrl_in; m_d1 = d1; m_d2 = d2; m_imm = ref_imm(instr_in);
                m_pc = pc_in; m_rs1 = r1; m_rs2 = r2; m_rd = instr_in[11:7];
            end
        end
        if (wb_we && wb_addr != 5'd0) m_rf[wb_addr] = wb_data;
        #1;
        check_outputs(tag);
        @(negedge clk);
    endtask

    initial begin
        logic [6:0]  ops [10];
        logic [31:0] held_pc;
        logic [31:0] ins;
        ops = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h00};

        rst = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 8'd0, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs("reset");
        rst = 1'b1;
        #1 check("reset.in_ready", 64'(in_ready), 64'd1);

        // ADDI x1,x0,-5
        drive(1'b1, 32'hFFB00093, 32'h100, 8'h03, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
        cycle("addi");
        check("addi.imm_const", 64'(out_imm), 64'hFFFFFFFB);
        check("addi.rd_const",  64'(out_rd),  64'd1);

        // Write x5 then read it; write x0 then read it
        drive(1'b0, 32'd0, 32'd0, 8'd0, 1'b0, 1'b1, 1'b1, 5'd5, 32'h1234);
        cycle("wb_x5");
        drive(1'b1, 32'h00028313, 32'h104, 8'h01, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
        cycle("rd_x5");
        check("rd_x5.const", 64'(out_rs1_data), 64'h1234);
        drive(1'b0, 32'd0, 32'd0, 8'd0, 1'b0, 1'b1, 1'b1, 5'd0, 32'hFFFF);
        cycle("wb_x0");
        drive(1'b1, 32'h00000013, 32'h108, 8'h01, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
        cycle("rd_x0");
        check("rd_x0.const", 64'(out_rs1_data), 64'd0);

        // Load-use: LW x3 then ADD x4,x3,x2
        drive(1'b1, 32'h00002183, 32'h10C, 8'h80, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
        cycle("lw");
        drive(1'b1, 32'h00218233, 32'h110, 8'h01, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
        cycle("lu_bubble");
        check("lu.in_ready_low", 64'(last_rdy), 64'd0);
        check("lu.bubble_valid", 64'(out_valid), 64'd0);
        check("lu.bubble_ctrl",  64'(out_ctrl),  64'd0);
        cycle("lu_accept");
        check("lu.accept_valid", 64'(out_valid), 64'd1);
        check("lu.accept_rd",    64'(out_rd),    64'd4);

        // Stall three cycles, then flush during the stall
        held_pc = out_pc;
        drive(1'b1, 32'h00500393, 32'h114, 8'h02, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        for (int k = 0; k < 3; k++) begin
            cycle("stall");
            check("stall.in_ready_low", 64'(last_rdy), 64'd0);
            check("stall.pc_hold", 64'(out_pc), 64'(held_pc));
        end
        flush = 1'b1;
        cycle("flush");
        check("flush.valid", 64'(out_valid), 64'd0);

        // Same-cycle write/read of x7
        drive(1'b0, 32'd0, 32'd0, 8'd0, 1'b0, 1'b1, 1'b1, 5'd7, 32'h55);
        cycle("wb_x7_old");
        drive(1'b1, 32'h00038413, 32'h118, 8'h01, 1'b0, 1'b1, 1'b1, 5'd7, 32'hAA);
        cycle("bypass");
`ifdef ID_EX_WB_BYPASS_EN
        check("bypass.const", 64'(out_rs1_data), 64'hAA);
`else
        check("bypass.const", 64'(out_rs1_data), 64'h55);
`endif

        // Asynchronous reset mid-stream
        drive(1'b1, 32'h00100093, 32'h11C, 8'h01, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
        cycle("pre_rst");
        check("pre_rst.valid", 64'(out_valid), 64'd1);
        #2 rst = 1'b0;
        #1 check("async_rst.valid", 64'(out_valid), 64'd0);
        model_reset();
        check_outputs("async_rst");
        @(negedge clk);
        rst = 1'b1;

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            ins = $urandom;
            ins[6:0] = ops[$urandom_range(0, 9)];
            drive(($urandom_range(0, 3) != 0), ins, $urandom, 8'($urandom),
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 31)), $urandom);
            cycle("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
